// File: rtl/dmem_responder.sv
// Data-memory responder for a pipeline memory stage: each request is held by the
// initiator, waits WAIT_CYCLES, then completes with a one-cycle ready strobe.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        stall,
    output logic [1:0]  dbg_state
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Handshake: the initiator raises req with stable we/addr/wdata/be and holds them
    // until the cycle in which ready=1; stall = req & ~ready freezes the pipeline meanwhile.

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          enter_resp;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          fault;
    logic [AW-1:0] idx;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_q [DEPTH_WORDS];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    // Initiator withdrew the request: abandon it without touching storage.
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the capturing edge, so use live inputs.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_be    = be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    always_comb begin
        fault  = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
        idx    = acc_addr[AW+1:2];
        mem_we = rst && enter_resp && acc_we && !fault;
        for (int b = 0; b < 4; b++) begin
            mem_wdata[8*b +: 8] = acc_be[b] ? acc_wdata[8*b +: 8] : mem_q[idx][8*b +: 8];
        end
        ready_d = enter_resp;
        err_d   = enter_resp && fault;
        rdata_d = (enter_resp && !acc_we && !fault) ? mem_q[idx] : 32'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= mem_wdata;
        end
    end

    assign ready     = ready_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign stall     = req & ~ready_q;
    assign dbg_state = state_q;

endmodule
